// File: rtl/pcie_msix_irq_sched.sv
// pcie_msix_irq_sched
//   Schedules MSI-X interrupt requests from IRQ_COUNT internal sources onto
//   the single cfg_interrupt_msix_* port of the PCIe hard block. A small
//   per-vector table (address, data, mask) is written by the BAR register
//   logic. Requests coalesce into per-vector pending bits. A round-robin
//   arbiter grants one eligible vector at a time. A failed or timed-out
//   message is reissued up to MAX_RETRY times; after that the vector is dropped.
//
// Ports
//   clk, rst_n                   clock, asynchronous active-low reset
//   irq_req                      per-vector request; every high cycle sets pending
//   tbl_wr_*                     table write port (index, address, data, mask)
//   cfg_interrupt_msix_enable    bit 0: PF0 MSI-X enable
//   cfg_interrupt_msix_mask      bit 0: PF0 function mask
//   cfg_interrupt_msix_address   message address for the current issue
//   cfg_interrupt_msix_data      message data for the current issue
//   cfg_interrupt_msix_int       single-cycle issue pulse
//   cfg_interrupt_msix_sent      IP reports the message was sent
//   cfg_interrupt_msix_fail      IP reports the message failed
//   irq_pending                  current pending bits
//   busy                         scheduler is not idle
//   drop_count                   saturating count of dropped vectors
module pcie_msix_irq_sched #(
    parameter int IRQ_COUNT = 8,
    parameter int IDX_WIDTH = $clog2(IRQ_COUNT),
    parameter int MAX_RETRY = 3,
    parameter int RETRY_GAP = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IRQ_COUNT-1:0] irq_req,
    input  logic                 tbl_wr_en,
    input  logic [IDX_WIDTH-1:0] tbl_wr_idx,
    input  logic [63:0]          tbl_wr_addr,
    input  logic [31:0]          tbl_wr_data,
    input  logic                 tbl_wr_mask,
    input  logic [1:0]           cfg_interrupt_msix_enable,
    input  logic [1:0]           cfg_interrupt_msix_mask,
    output logic [63:0]          cfg_interrupt_msix_address,
    output logic [31:0]          cfg_interrupt_msix_data,
    output logic                 cfg_interrupt_msix_int,
    input  logic                 cfg_interrupt_msix_sent,
    input  logic                 cfg_interrupt_msix_fail,
    output logic [IRQ_COUNT-1:0] irq_pending,
    output logic                 busy,
    output logic [15:0]          drop_count
);

    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int TIMER_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int GAP_W   = (RETRY_GAP < 2) ? 1 : $clog2(RETRY_GAP);

    localparam logic [RETRY_W-1:0]   RETRY_LAST = RETRY_W'(MAX_RETRY);
    localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]     GAP_LAST   = GAP_W'(RETRY_GAP - 1);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST   = IDX_WIDTH'(IRQ_COUNT - 1);
    localparam logic [IDX_WIDTH:0]   IDX_COUNT  = (IDX_WIDTH + 1)'(IRQ_COUNT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_FAIL
    } state_t;

    state_t               state_q, state_d;
    logic [IRQ_COUNT-1:0] pending_q, pending_d;
    logic [IRQ_COUNT-1:0] pend_clr;
    logic [63:0]          tbl_addr_q [IRQ_COUNT];
    logic [63:0]          tbl_addr_d [IRQ_COUNT];
    logic [31:0]          tbl_data_q [IRQ_COUNT];
    logic [31:0]          tbl_data_d [IRQ_COUNT];
    logic [IRQ_COUNT-1:0] tbl_mask_q, tbl_mask_d;
    logic [IDX_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_WIDTH-1:0] cur_idx_q, cur_idx_d;
    logic [63:0]          addr_q, addr_d;
    logic [31:0]          data_q, data_d;
    logic                 int_q, int_d;
    logic [RETRY_W-1:0]   retry_q, retry_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [GAP_W-1:0]     gap_q, gap_d;
    logic [15:0]          drop_q, drop_d;

    logic [IRQ_COUNT-1:0] elig;
    logic                 grant_found;
    logic [IDX_WIDTH-1:0] grant_idx;
    logic [IDX_WIDTH:0]   cand;
    logic [IDX_WIDTH-1:0] next_ptr;
    logic                 cfg_unused;

    // Only PF0 controls are consumed.
    assign cfg_unused = ^{cfg_interrupt_msix_enable[1], cfg_interrupt_msix_mask[1]};

    // Table write port; out-of-range indices match no entry and are ignored.
    always_comb begin
        tbl_addr_d = tbl_addr_q;
        tbl_data_d = tbl_data_q;
        tbl_mask_d = tbl_mask_q;
        for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
            if (tbl_wr_en && (tbl_wr_idx == IDX_WIDTH'(i))) begin
                tbl_addr_d[i] = tbl_wr_addr;
                tbl_data_d[i] = tbl_wr_data;
                tbl_mask_d[i] = tbl_wr_mask;
            end
        end
    end

    // Round-robin search starting at rr_ptr_q, wrapping modulo IRQ_COUNT.
    always_comb begin
        elig        = pending_q & ~tbl_mask_q &
                      {IRQ_COUNT{cfg_interrupt_msix_enable[0] & ~cfg_interrupt_msix_mask[0]}};
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_WIDTH + 1)'(i);
            if (cand >= IDX_COUNT) begin
                cand = cand - IDX_COUNT;
            end
            if (!grant_found && elig[cand[IDX_WIDTH-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDX_WIDTH-1:0];
            end
        end
    end

    assign next_ptr = (cur_idx_q == IDX_LAST) ? '0 : cur_idx_q + 1'b1;

    // Scheduler FSM. int is registered from ISSUE, so the pulse lands in the
    // first WAIT cycle; the timeout timer starts from that same cycle.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        cur_idx_d = cur_idx_q;
        addr_d    = addr_q;
        data_d    = data_q;
        int_d     = 1'b0;
        retry_d   = retry_q;
        timer_d   = timer_q;
        gap_d     = gap_q;
        drop_d    = drop_q;
        pend_clr  = '0;

        case (state_q)
            ST_IDLE: begin
                if (grant_found) begin
                    cur_idx_d = grant_idx;
                    addr_d    = tbl_addr_q[grant_idx];
                    data_d    = tbl_data_q[grant_idx];
                    retry_d   = '0;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                int_d   = 1'b1;
                timer_d = '0;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (cfg_interrupt_msix_sent) begin
                    pend_clr[cur_idx_q] = 1'b1;
                    rr_ptr_d            = next_ptr;
                    state_d             = ST_IDLE;
                end else if (cfg_interrupt_msix_fail || (timer_q == TIMER_LAST)) begin
                    gap_d   = '0;
                    state_d = ST_FAIL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_FAIL: begin
                if (retry_q == RETRY_LAST) begin
                    pend_clr[cur_idx_q] = 1'b1;
                    drop_d              = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                    rr_ptr_d            = next_ptr;
                    state_d             = ST_IDLE;
                end else if (gap_q == GAP_LAST) begin
                    retry_d = retry_q + 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A request in the same cycle as the clear keeps the bit set.
        pending_d = (pending_q & ~pend_clr) | irq_req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            pending_q <= '0;
            for (int unsigned i = 0; i < IRQ_COUNT; i++) begin
                tbl_addr_q[i] <= '0;
                tbl_data_q[i] <= '0;
            end
            tbl_mask_q <= '1;
            rr_ptr_q   <= '0;
            cur_idx_q  <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            int_q      <= 1'b0;
            retry_q    <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            tbl_addr_q <= tbl_addr_d;
            tbl_data_q <= tbl_data_d;
            tbl_mask_q <= tbl_mask_d;
            rr_ptr_q   <= rr_ptr_d;
            cur_idx_q  <= cur_idx_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            int_q      <= int_d;
            retry_q    <= retry_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            drop_q     <= drop_d;
        end
    end

    assign cfg_interrupt_msix_address = addr_q;
    assign cfg_interrupt_msix_data    = data_q;
    assign cfg_interrupt_msix_int     = int_q;
    assign irq_pending                = pending_q;
    assign busy                       = (state_q != ST_IDLE);
    assign drop_count                 = drop_q;

endmodule
